midi_synth_poly: RTL and testbench
==================================

// Module: midi_synth_poly
// PURPOSE
//  Parametrised polyphonic synth core: N time-multiplexed sawtooth voices, velocity scaling, saturating mix.
//  Sits between spi_controller command outputs and the DAC interface.
//  Emits one mixed sample per CLK_DIV clocks with a valid strobe.
//  Replaces the fixed voice_controller path.
// PARAMETERS
//  NUM_VOICES  8     number of voices, 2..64
//  OUT_W       16    output sample width (signed or offset binary)
//  TUNE_W      32    phase accumulator / tuning code width, TUNE_W >= OUT_W
//  CLK_DIV     1024  clocks per output sample; must be >= NUM_VOICES+2, elaboration error otherwise
// PORTS
//  i_clk            in   1                 system clock
//  i_reset          in   1                 synchronous, active-high reset
//  i_cmd_valid      in   1                 one-cycle command strobe (spi_controller flag)
//  i_note_status    in   1                 1 = note-on, 0 = note-off
//  i_voice_index    in   8                 target voice
//  i_tuning_code    in   TUNE_W            phase increment per sample
//  i_velocity       in   7                 amplitude, 0..127
//  o_sample         out  OUT_W             mixed sample, held between strobes
//  o_sample_valid   out  1                 one-cycle pulse when o_sample updates
//  o_clip           out  1                 high for the sample period after a saturated mix
//  o_cmd_err        out  1                 one-cycle pulse: command had voice index >= NUM_VOICES
//  o_active_count   out  $clog2(NUM_VOICES+1)  registered count of active voices
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high on i_reset.
//  - Reset: all outputs 0. Every voice inactive; phase, tune and vel are 0. Divider is 0. FSM is in S_WAIT.
//  - Per-voice state: active, phase[TUNE_W], tune[TUNE_W], vel[7].
//  - Commands are accepted in any FSM state, on the cycle i_cmd_valid is high:
//    - Note-on: active=1, tune and vel loaded. Phase is kept if the voice was already active, cleared to 0 otherwise.
//    - Note-off: active=0, phase=0. tune and vel are kept.
//    - Index >= NUM_VOICES: no state change; o_cmd_err pulses on the next cycle.
//  - Divider: free-running count 0..CLK_DIV-1, wraps. Count==0 in S_WAIT moves the FSM to S_SCAN and clears acc.
//  - S_SCAN runs NUM_VOICES cycles, voice index v=0..N-1, one voice per cycle. For voice v:
//    - w = phase[v][TUNE_W-1 -: OUT_W], read as signed (sawtooth).
//    - c = (w * {1'b0,vel[v]}) >>> 7, arithmetic shift. Contribution is 0 if the voice is inactive.
//    - acc += c. acc is signed, width OUT_W+$clog2(NUM_VOICES)+1, so it never overflows.
//    - If active: phase[v] += tune[v], modulo 2^TUNE_W (wraps silently). The sample uses the pre-increment phase.
//  - Command on the same cycle S_SCAN processes that voice: the command write wins.
//    - Scan contribution uses the old values.
//    - The phase increment for that voice is dropped for that period.
//  - S_SAT (1 cycle): acc is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//    - o_sample, o_clip and o_active_count are registered at the end of S_SAT, with o_sample_valid=1 for one cycle.
//    - FSM returns to S_WAIT.
//  - Latency: o_sample_valid is high exactly NUM_VOICES+2 clocks after the divider count==0 cycle. Period is exactly CLK_DIV.
//  - i_reset asserted mid-scan: partial acc is discarded, no strobe, full reset state.
// CONFIGURATION
//  - OFFSET_BINARY_EN defined: o_sample = saturated value + 2^(OUT_W-1), i.e. MSB inverted, unsigned offset binary for the DAC.
//    - Reset value of o_sample is still 0.
//  - OFFSET_BINARY_EN undefined: o_sample is two's complement.
//  - Clip detection and all timing are identical in both builds.
// TESTING
//  1. Reset held 3 cycles mid-scan -> all outputs 0, no o_sample_valid, next strobe at divider count 0 + N+2.
//  2. Voice 0 note-on, tune=2^(TUNE_W-4), vel=127, N=8, OUT_W=16 -> samples step by 4096*127>>7, giving a 16-sample saw period that wraps -32768 -> 32767 region.
//  3. All 8 voices on, same phase near +max, vel=127 -> o_sample=32767, o_clip=1 (offset build: 65535).
//  4. Command with index 8 (N=8) -> o_cmd_err pulses 1 cycle, o_active_count unchanged, mix unchanged.
//  5. Note-off for voice 3 on its scan cycle -> this sample includes voice 3's old contribution, the next sample excludes it, phase[3]=0, o_active_count decrements.
//  6. Velocity 0 note-on -> o_active_count increments, sample contribution 0. Re-note-on of an active voice keeps phase continuity (no step at retune).

Source files
------------

// File: rtl/midi_synth_poly.sv
// Polyphonic sawtooth synth: NUM_VOICES time-multiplexed voices, velocity scaling, saturating mix; OFFSET_BINARY_EN selects offset-binary output.
// Strobe NUM_VOICES+2 clocks after each divider wrap, one per CLK_DIV; no backpressure, commands accepted every cycle.
module midi_synth_poly #(
    parameter int NUM_VOICES = 8,
    parameter int OUT_W      = 16,
    parameter int TUNE_W     = 32,
    parameter int CLK_DIV    = 1024
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_cmd_valid,
    input  logic                              i_note_status,
    input  logic [7:0]                        i_voice_index,
    input  logic [TUNE_W-1:0]                 i_tuning_code,
    input  logic [6:0]                        i_velocity,
    output logic [OUT_W-1:0]                  o_sample,
    output logic                              o_sample_valid,
    output logic                              o_clip,
    output logic                              o_cmd_err,
    output logic [$clog2(NUM_VOICES+1)-1:0]   o_active_count
);
    localparam int VIDX_W = $clog2(NUM_VOICES);
    localparam int CNT_W  = $clog2(NUM_VOICES + 1);
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int ACC_W  = OUT_W + VIDX_W + 1;
    localparam int PROD_W = OUT_W + 8;

    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_SAT  = 2'd2;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    generate
        if (CLK_DIV < NUM_VOICES + 2) begin : g_bad_clk_div
            $error("CLK_DIV must be >= NUM_VOICES+2");
        end
        if (TUNE_W < OUT_W) begin : g_bad_tune_w
            $error("TUNE_W must be >= OUT_W");
        end
    endgenerate

    logic [1:0]              r_state;
    logic [DIV_W-1:0]        r_div;
    logic [VIDX_W-1:0]       r_vidx;
    logic signed [ACC_W-1:0] r_acc;
    logic [NUM_VOICES-1:0]   r_active;
    logic [TUNE_W-1:0]       r_phase [NUM_VOICES];
    logic [TUNE_W-1:0]       r_tune  [NUM_VOICES];
    logic [6:0]              r_vel   [NUM_VOICES];

    logic [OUT_W-1:0]        r_sample;
    logic                    r_sample_valid;
    logic                    r_clip;
    logic                    r_cmd_err;
    logic [CNT_W-1:0]        r_active_cnt;

    logic signed [OUT_W-1:0]  w_saw;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_contrib;
    logic signed [ACC_W-1:0]  w_acc_clamped;
    logic                     w_clip;
    logic [OUT_W-1:0]         w_out;
    logic                     w_cmd_in_range;
    logic [VIDX_W-1:0]        w_cmd_idx;
    logic [CNT_W-1:0]         w_active_cnt;

    always_comb begin
        w_cmd_in_range = int'(i_voice_index) < NUM_VOICES;
        w_cmd_idx      = i_voice_index[VIDX_W-1:0];

        // Top OUT_W phase bits are the signed sawtooth; velocity is an unsigned 7-bit gain of /128
        w_saw     = r_phase[r_vidx][TUNE_W-1 -: OUT_W];
        w_prod    = PROD_W'(w_saw) * PROD_W'($signed({1'b0, r_vel[r_vidx]}));
        w_contrib = r_active[r_vidx] ? ACC_W'(w_prod >>> 7) : '0;

        w_clip        = (r_acc > ACC_MAX) || (r_acc < ACC_MIN);
        w_acc_clamped = r_acc;
        if (r_acc > ACC_MAX) begin
            w_acc_clamped = ACC_MAX;
        end else if (r_acc < ACC_MIN) begin
            w_acc_clamped = ACC_MIN;
        end
`ifdef OFFSET_BINARY_EN
        w_out = OUT_W'(w_acc_clamped) ^ {1'b1, {(OUT_W-1){1'b0}}};
`else
        w_out = OUT_W'(w_acc_clamped);
`endif

        w_active_cnt = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_active_cnt = w_active_cnt + CNT_W'(r_active[v]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= S_WAIT;
            r_div          <= '0;
            r_vidx         <= '0;
            r_acc          <= '0;
            r_active       <= '0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_clip         <= 1'b0;
            r_cmd_err      <= 1'b0;
            r_active_cnt   <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_phase[v] <= '0;
                r_tune[v]  <= '0;
                r_vel[v]   <= '0;
            end
        end else begin
            r_sample_valid <= 1'b0;
            r_cmd_err      <= i_cmd_valid && !w_cmd_in_range;
            r_div          <= (r_div == DIV_W'(CLK_DIV - 1)) ? '0 : r_div + DIV_W'(1);

            case (r_state)
                S_WAIT: begin
                    if (r_div == '0) begin
                        r_state <= S_SCAN;
                        r_vidx  <= '0;
                        r_acc   <= '0;
                    end
                end
                S_SCAN: begin
                    r_acc <= r_acc + w_contrib;
                    if (r_active[r_vidx]) begin
                        r_phase[r_vidx] <= r_phase[r_vidx] + r_tune[r_vidx];
                    end
                    if (r_vidx == VIDX_W'(NUM_VOICES - 1)) begin
                        r_state <= S_SAT;
                    end else begin
                        r_vidx <= r_vidx + VIDX_W'(1);
                    end
                end
                S_SAT: begin
                    r_sample       <= w_out;
                    r_clip         <= w_clip;
                    r_active_cnt   <= w_active_cnt;
                    r_sample_valid <= 1'b1;
                    r_state        <= S_WAIT;
                end
                default: r_state <= S_WAIT;
            endcase

            // Placed after the scan update so a colliding command overrides that voice's phase step
            if (i_cmd_valid && w_cmd_in_range) begin
                if (i_note_status) begin
                    r_active[w_cmd_idx] <= 1'b1;
                    r_tune[w_cmd_idx]   <= i_tuning_code;
                    r_vel[w_cmd_idx]    <= i_velocity;
                    r_phase[w_cmd_idx]  <= r_active[w_cmd_idx] ? r_phase[w_cmd_idx] : '0;
                end else begin
                    r_active[w_cmd_idx] <= 1'b0;
                    r_phase[w_cmd_idx]  <= '0;
                end
            end
        end
    end

    assign o_sample       = r_sample;
    assign o_sample_valid = r_sample_valid;
    assign o_clip         = r_clip;
    assign o_cmd_err      = r_cmd_err;
    assign o_active_count = r_active_cnt;

endmodule

// File: tb/tb_midi_synth_poly.sv
// Directed bench for midi_synth_poly (N=8, OUT_W=16, TUNE_W=32, CLK_DIV=16), two's-complement build.
module tb_midi_synth_poly;
    localparam int NV = 8;
    localparam int OW = 16;
    localparam int TW = 32;
    localparam int CD = 16;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_cmd_valid;
    logic          i_note_status;
    logic [7:0]    i_voice_index;
    logic [TW-1:0] i_tuning_code;
    logic [6:0]    i_velocity;
    logic [OW-1:0] o_sample;
    logic          o_sample_valid;
    logic          o_clip;
    logic          o_cmd_err;
    logic [3:0]    o_active_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    midi_synth_poly #(
        .NUM_VOICES(NV), .OUT_W(OW), .TUNE_W(TW), .CLK_DIV(CD)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid),
        .i_note_status(i_note_status), .i_voice_index(i_voice_index),
        .i_tuning_code(i_tuning_code), .i_velocity(i_velocity),
        .o_sample(o_sample), .o_sample_valid(o_sample_valid), .o_clip(o_clip),
        .o_cmd_err(o_cmd_err), .o_active_count(o_active_count)
    );

    always #5 i_clk = ~i_clk;

    // cyc n is the negedge just before the posedge that sees inputs driven at n; divider is 0 at posedge 0
    task automatic tick();
        @(negedge i_clk);
        cyc++;
    endtask

    task automatic goto_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset(input int n);
        i_reset = 1'b1; i_cmd_valid = 1'b0; i_note_status = 1'b0;
        i_voice_index = '0; i_tuning_code = '0; i_velocity = '0;
        repeat (n) @(negedge i_clk);
        i_reset = 1'b0;
        cyc = 0;
    endtask

    task automatic cmd(input logic on, input int idx, input logic [TW-1:0] tune, input int vel);
        i_cmd_valid = 1'b1; i_note_status = on; i_voice_index = 8'(idx);
        i_tuning_code = tune; i_velocity = 7'(vel);
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        bit seen;
        do_reset(3);
        checks++;
        if ({o_sample, o_sample_valid, o_clip, o_cmd_err, o_active_count} !== '0) begin
            errors++; $display("FAIL reset_state: got sample=%h vld=%b clip=%b err=%b cnt=%0d, want all 0",
                               o_sample, o_sample_valid, o_clip, o_cmd_err, o_active_count);
        end
        cmd(1'b1, 0, 32'h1000_0000, 127);
        goto_cyc(26);
        checks++;
        if (o_sample_valid !== 1'b1 || $signed(o_sample) !== 4064 || o_active_count !== 4'd1) begin
            errors++; $display("FAIL reset_pre_sample: got vld=%b sample=%0d cnt=%0d, want 1 4064 1",
                               o_sample_valid, $signed(o_sample), o_active_count);
        end
        goto_cyc(36);
        i_reset = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            tick();
            if (o_sample_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen || {o_sample, o_sample_valid, o_clip, o_cmd_err, o_active_count} !== '0) begin
            errors++; $display("FAIL reset_mid_scan: got strobe_seen=%b sample=%h cnt=%0d, want 0 0 0",
                               seen, o_sample, o_active_count);
        end
        i_reset = 1'b0;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (o_sample_valid === 1'b1) break;
        end
        checks++;
        if (n !== 10) begin
            errors++; $display("FAIL reset_strobe_latency: got %0d cycles, want 10", n);
        end
        checks++;
        if (o_sample !== '0 || o_active_count !== 4'd0 || o_clip !== 1'b0) begin
            errors++; $display("FAIL reset_first_sample: got sample=%h cnt=%0d clip=%b, want 0 0 0",
                               o_sample, o_active_count, o_clip);
        end
    endtask

    task automatic test_saw();
        int m;
        int exp_s;
        do_reset(2);
        cmd(1'b1, 0, 32'h1000_0000, 127);
        for (int k = 0; k <= 16; k++) begin
            goto_cyc(16 * k + 10);
            m = k % 16;
            if (m >= 8) m = m - 16;
            exp_s = 4064 * m;
            checks++;
            if (o_sample_valid !== 1'b1 || $signed(o_sample) !== exp_s || o_clip !== 1'b0) begin
                errors++; $display("FAIL saw_k%0d: got vld=%b sample=%0d clip=%b, want 1 %0d 0",
                                   k, o_sample_valid, $signed(o_sample), o_clip, exp_s);
            end
            if (k == 1) begin
                tick();
                checks++;
                if (o_sample_valid !== 1'b0 || $signed(o_sample) !== 4064) begin
                    errors++; $display("FAIL saw_pulse_hold: got vld=%b sample=%0d, want 0 4064",
                                       o_sample_valid, $signed(o_sample));
                end
            end
        end
    endtask

    task automatic test_clip();
        do_reset(2);
        for (int v = 0; v < NV; v++) cmd(1'b1, v, 32'h7000_0000, 127);
        goto_cyc(10);
        checks++;
        if (o_sample !== '0 || o_active_count !== 4'd8 || o_clip !== 1'b0) begin
            errors++; $display("FAIL clip_p0: got sample=%0d cnt=%0d clip=%b, want 0 8 0",
                               $signed(o_sample), o_active_count, o_clip);
        end
        goto_cyc(26);
        checks++;
        if ($signed(o_sample) !== 32767 || o_clip !== 1'b1) begin
            errors++; $display("FAIL clip_pos: got sample=%0d clip=%b, want 32767 1", $signed(o_sample), o_clip);
        end
        goto_cyc(42);
        checks++;
        if ($signed(o_sample) !== -32768 || o_clip !== 1'b1) begin
            errors++; $display("FAIL clip_neg: got sample=%0d clip=%b, want -32768 1", $signed(o_sample), o_clip);
        end
        goto_cyc(58);
        checks++;
        if ($signed(o_sample) !== 32767 || o_clip !== 1'b1 || o_active_count !== 4'd8) begin
            errors++; $display("FAIL clip_pos2: got sample=%0d clip=%b cnt=%0d, want 32767 1 8",
                               $signed(o_sample), o_clip, o_active_count);
        end
    endtask

    task automatic test_cmd_err();
        do_reset(2);
        cmd(1'b1, 0, 32'h1000_0000, 127);
        cmd(1'b0, 8, 32'h0, 0);
        checks++;
        if (o_cmd_err !== 1'b1) begin
            errors++; $display("FAIL cmd_err_pulse: got %b, want 1", o_cmd_err);
        end
        tick();
        checks++;
        if (o_cmd_err !== 1'b0) begin
            errors++; $display("FAIL cmd_err_width: got %b, want 0", o_cmd_err);
        end
        goto_cyc(10);
        checks++;
        if (o_sample !== '0 || o_active_count !== 4'd1) begin
            errors++; $display("FAIL cmd_err_p0: got sample=%0d cnt=%0d, want 0 1", $signed(o_sample), o_active_count);
        end
        goto_cyc(12);
        cmd(1'b1, 255, 32'h1000_0000, 127);
        checks++;
        if (o_cmd_err !== 1'b1) begin
            errors++; $display("FAIL cmd_err_255: got %b, want 1", o_cmd_err);
        end
        goto_cyc(26);
        checks++;
        if ($signed(o_sample) !== 4064 || o_active_count !== 4'd1) begin
            errors++; $display("FAIL cmd_err_mix: got sample=%0d cnt=%0d, want 4064 1", $signed(o_sample), o_active_count);
        end
    endtask

    task automatic test_note_off_collision();
        do_reset(2);
        cmd(1'b1, 0, 32'h1000_0000, 127);
        cmd(1'b1, 3, 32'h2000_0000, 127);
        goto_cyc(10);
        checks++;
        if (o_sample !== '0 || o_active_count !== 4'd2) begin
            errors++; $display("FAIL off_p0: got sample=%0d cnt=%0d, want 0 2", $signed(o_sample), o_active_count);
        end
        goto_cyc(26);
        checks++;
        if ($signed(o_sample) !== 12192) begin
            errors++; $display("FAIL off_p1: got %0d, want 12192", $signed(o_sample));
        end
        goto_cyc(36);
        cmd(1'b0, 3, 32'h0, 0);
        goto_cyc(42);
        checks++;
        if ($signed(o_sample) !== 24384 || o_active_count !== 4'd1) begin
            errors++; $display("FAIL off_collide: got sample=%0d cnt=%0d, want 24384 1", $signed(o_sample), o_active_count);
        end
        goto_cyc(58);
        checks++;
        if ($signed(o_sample) !== 12192 || o_active_count !== 4'd1) begin
            errors++; $display("FAIL off_after: got sample=%0d cnt=%0d, want 12192 1", $signed(o_sample), o_active_count);
        end
    endtask

    task automatic test_vel0_retune();
        do_reset(2);
        cmd(1'b1, 2, 32'h1000_0000, 127);
        cmd(1'b1, 5, 32'h1000_0000, 0);
        goto_cyc(10);
        checks++;
        if (o_sample !== '0 || o_active_count !== 4'd2) begin
            errors++; $display("FAIL vel0_count: got sample=%0d cnt=%0d, want 0 2", $signed(o_sample), o_active_count);
        end
        goto_cyc(26);
        checks++;
        if ($signed(o_sample) !== 4064) begin
            errors++; $display("FAIL vel0_mix: got %0d, want 4064", $signed(o_sample));
        end
        goto_cyc(28);
        cmd(1'b1, 2, 32'h2000_0000, 127);
        goto_cyc(42);
        checks++;
        if ($signed(o_sample) !== 8128 || o_active_count !== 4'd2) begin
            errors++; $display("FAIL retune_cont: got sample=%0d cnt=%0d, want 8128 2", $signed(o_sample), o_active_count);
        end
        goto_cyc(51);
        cmd(1'b1, 2, 32'h2000_0000, 64);
        goto_cyc(58);
        checks++;
        if ($signed(o_sample) !== 16256) begin
            errors++; $display("FAIL retune_collide_old: got %0d, want 16256", $signed(o_sample));
        end
        goto_cyc(74);
        checks++;
        if ($signed(o_sample) !== 8192) begin
            errors++; $display("FAIL retune_step_dropped: got %0d, want 8192", $signed(o_sample));
        end
        goto_cyc(90);
        checks++;
        if ($signed(o_sample) !== 12288) begin
            errors++; $display("FAIL retune_next: got %0d, want 12288", $signed(o_sample));
        end
    endtask

    initial begin
        test_reset();
        test_saw();
        test_clip();
        test_cmd_err();
        test_note_off_collision();
        test_vel0_retune();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
